// File: rtl/computation_unit.sv
// computation_unit: shift/ALU/status stage with a valid/ready handshake.
// Results are committed to the registered C and status outputs, and out_valid
// pulses for one cycle when an operation completes.
// Defining COMPUTATION_MUL_EN adds the iterative shift-add multiplier (op 100),
// which takes WIDTH cycles. Without it, op 100 completes in one cycle with result 0.
module computation_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IMM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       shift,
    input  logic             asel,
    input  logic             bsel,
    input  logic             loadc,
    input  logic             loads,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       status
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_shifted;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             accept;

    // Completion bundle: either a single-cycle ALU result or the final multiply step
    logic             done_valid;
    logic [WIDTH-1:0] done_res;
    logic             done_v;
    logic             done_loadc;
    logic             done_loads;

    assign imm_ext = WIDTH'($signed(imm));

    // B pre-shift followed by the A/B operand select
    always_comb begin
        b_shifted = B;
        unique case (shift)
            2'b00: b_shifted = B;
            2'b01: b_shifted = {B[MSB-1:0], 1'b0};
            2'b10: b_shifted = {1'b0, B[MSB:1]};
            2'b11: b_shifted = {B[MSB], B[MSB:1]};
        endcase
        ain = asel ? '0 : A;
        bin = bsel ? imm_ext : b_shifted;
    end

    // Single-cycle ALU result and overflow flag
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        unique case (op)
            3'b000: begin
                alu_res = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            3'b001: begin
                alu_res = ain - bin;
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            3'b010: alu_res = ain & bin;
            3'b011: alu_res = ~bin;
            3'b100: alu_res = '0;
            3'b101: alu_res = ain | bin;
            3'b110: alu_res = ain ^ bin;
            3'b111: alu_res = bin;
        endcase
    end

`ifdef COMPUTATION_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               mul_loadc;
    logic               mul_loads;
    logic               is_mul;
    logic               last_step;

    assign is_mul    = (op == 3'b100);
    assign in_ready  = !reset && (state == ST_IDLE);
    assign busy      = (state == ST_MUL);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == ST_MUL) && (count == CW'(1));
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state: enter MUL on a multiply accept, leave on the last step
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
            ST_MUL:  if (last_step)        state_next = ST_IDLE;
        endcase
    end

    // Multiplier snapshot and one shift-add step per cycle in MUL
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_loadc <= 1'b0;
            mul_loads <= 1'b0;
        end else if (accept && is_mul) begin
            count     <= CW'(WIDTH);
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, ain};
            mplier    <= bin;
            mul_loadc <= loadc;
            mul_loads <= loads;
        end else if (state == ST_MUL) begin
            count  <= count - CW'(1);
            acc    <= acc_next;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[MSB:1]};
        end
    end

    // Completion select: multiply result on its last step, else ALU on accept
    always_comb begin
        done_valid = accept && !is_mul;
        done_res   = alu_res;
        done_v     = alu_v;
        done_loadc = loadc;
        done_loads = loads;
        if (last_step) begin
            done_valid = 1'b1;
            done_res   = acc_next[MSB:0];
            done_v     = |acc_next[2*WIDTH-1:WIDTH];
            done_loadc = mul_loadc;
            done_loads = mul_loads;
        end
    end
`else
    assign in_ready = !reset;
    assign busy     = 1'b0;
    assign accept   = in_valid && in_ready;

    // Completion select: every accepted op completes through the ALU
    always_comb begin
        done_valid = accept;
        done_res   = alu_res;
        done_v     = alu_v;
        done_loadc = loadc;
        done_loads = loads;
    end
`endif

    // Result, status and completion-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            C         <= '0;
            status    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= done_valid;
            if (done_valid && done_loadc) C <= done_res;
            if (done_valid && done_loads) status <= {done_v, done_res[MSB], (done_res == '0)};
        end
    end

endmodule

// File: tb/tb_computation_unit.sv
// Directed self-checking bench for computation_unit at WIDTH=16, IMM_W=5.
// Multiply expectations follow COMPUTATION_MUL_EN when it is defined.
module tb_computation_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  imm;
    logic        out_valid;
    logic        busy;
    logic [15:0] C;
    logic [2:0]  status;

    int total = 0;
    int bad   = 0;

    computation_unit #(.WIDTH(16), .IMM_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .shift(shift), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
        .A(A), .B(B), .imm(imm), .out_valid(out_valid), .busy(busy), .C(C), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [1:0] sh, input logic as, input logic bs,
                         input logic lc, input logic ls, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] im);
        op = o; shift = sh; asel = as; bsel = bs; loadc = lc; loads = ls; A = a; B = b; imm = im;
    endtask

    task automatic fire;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input logic [15:0] c_exp, input logic [2:0] s_exp);
        check({tag, "_ov"}, 16'(out_valid), 16'd1);
        check({tag, "_C"}, C, c_exp);
        check({tag, "_st"}, 16'(status), 16'(s_exp));
    endtask

    task automatic mul_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c_exp, input logic [2:0] s_exp);
        int n;
        drive(3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, a, b, 5'd0);
        fire;
        n = 0;
        while (!out_valid && n < 64) begin
            step;
            n++;
        end
        check({tag, "_lat"}, 16'(n), 16'd16);
        expect_done(tag, c_exp, s_exp);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        in_valid = 1'b0;
        drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0);
        step;
        step;
        check("rst_C", C, 16'h0000);
        check("rst_st", 16'(status), 16'd0);
        check("rst_ov", 16'(out_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        #1;
        check("rst_rdy", 16'(in_ready), 16'd1);

        // ADD with signed overflow
        drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h0001, 5'd0);
        fire;
        expect_done("add_ovf", 16'h8000, 3'b110);
        step;
        check("add_ov_drop", 16'(out_valid), 16'd0);

        // SUB 0 - sext(-16) without status load, then with it
        drive(3'b001, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678, 5'b10000);
        fire;
        expect_done("sub_nols", 16'h0010, 3'b110);
        drive(3'b001, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 5'b10000);
        fire;
        expect_done("sub_imm", 16'h0010, 3'b000);

        // SUB signed overflow and ADD wrap to zero
        drive(3'b001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 16'h0001, 5'd0);
        fire;
        expect_done("sub_ovf", 16'h7FFF, 3'b100);
        drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 5'd0);
        fire;
        expect_done("add_wrap", 16'h0000, 3'b001);

        // MOV with loadc=0: C holds, status still loads
        drive(3'b111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8002, 5'd0);
        fire;
        expect_done("mov_noc", 16'h0000, 3'b010);

        // B pre-shifts through MOV
        drive(3'b111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h8002, 5'd0);
        fire;
        expect_done("asr", 16'hC001, 3'b010);
        drive(3'b111, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h8002, 5'd0);
        fire;
        expect_done("lsr", 16'h4001, 3'b000);
        drive(3'b111, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h8002, 5'd0);
        fire;
        expect_done("lsl", 16'h0004, 3'b000);

        // MVN and OR
        drive(3'b011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h0F0F, 5'd0);
        fire;
        expect_done("mvn", 16'hF0F0, 3'b010);
        drive(3'b101, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF000, 16'h000F, 5'd0);
        fire;
        expect_done("or", 16'hF00F, 3'b010);

        // Back-to-back ADD, AND, XOR on consecutive edges
        in_valid = 1'b1;
        drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF0F0, 16'h0F0F, 5'd0);
        step;
        expect_done("b2b_add", 16'hFFFF, 3'b010);
        drive(3'b010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF0F0, 16'h0F0F, 5'd0);
        step;
        expect_done("b2b_and", 16'h0000, 3'b001);
        drive(3'b110, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF0F0, 16'h0F0F, 5'd0);
        step;
        expect_done("b2b_xor", 16'hFFFF, 3'b010);
        in_valid = 1'b0;
        step;
        check("b2b_end_ov", 16'(out_valid), 16'd0);

`ifdef COMPUTATION_MUL_EN
        // MUL with overflow into the upper half; a held request must be ignored
        drive(3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100, 5'd0);
        in_valid = 1'b1;
        step;
        drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0001, 5'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("mul_busy%0d", k), 16'(busy), 16'd1);
            check($sformatf("mul_rdy%0d", k), 16'(in_ready), 16'd0);
            check($sformatf("mul_ov%0d", k), 16'(out_valid), 16'd0);
            if (k == 15) in_valid = 1'b0;
            step;
        end
        expect_done("mul_ovf", 16'h0000, 3'b101);
        check("mul_done_busy", 16'(busy), 16'd0);
        check("mul_done_rdy", 16'(in_ready), 16'd1);
        step;
        check("mul_ov_drop", 16'(out_valid), 16'd0);

        mul_run("mul_zero", 16'h1234, 16'h0000, 16'h0000, 3'b001);
        mul_run("mul_ffff", 16'h00FF, 16'h0101, 16'hFFFF, 3'b010);

        // Reset five cycles into a multiply aborts it
        drive(3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0005, 5'd0);
        fire;
        for (int k = 0; k < 5; k++) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        check("abort_C", C, 16'h0000);
        check("abort_st", 16'(status), 16'd0);
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_rdy", 16'(in_ready), 16'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen++;
            step;
        end
        check("abort_no_ov", 16'(seen), 16'd0);
`else
        // Without the multiplier, op 100 completes in one cycle with result 0
        drive(3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100, 5'd0);
        fire;
        expect_done("mul_off", 16'h0000, 3'b001);
        check("mul_off_busy", 16'(busy), 16'd0);
        check("mul_off_rdy", 16'(in_ready), 16'd1);
        step;
        check("mul_off_ov_drop", 16'(out_valid), 16'd0);

        // Reset clears C and status
        drive(3'b111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 5'd0);
        fire;
        expect_done("pre_rst", 16'hA5A5, 3'b010);
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        check("rst2_C", C, 16'h0000);
        check("rst2_st", 16'(status), 16'd0);
        check("rst2_rdy", 16'(in_ready), 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
